hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 20 ++
 rtl/hazard_controller_mdu_sequencer.sv | 71 +++++++
 rtl/hazard_controller.sv | 92 +++++++++
 tb/tb_hazard_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: sequencer state encoding, forward-select
// codes and default multicycle latencies.
package hazard_controller_pkg;

  localparam int CNT_W       = 6;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // ALU operand source select
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_controller_mdu_sequencer.sv
// Multicycle multiply/divide sequencer: counts out the unit latency and
// issues a one-cycle HI/LO write strobe when the result is ready.
module mdu_sequencer
  import hazard_controller_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       div_i,
  output logic       busy_o,
  output logic       hilo_we_o,
  output mdu_state_e state_o
);

  // Start cycle, LAT-2 countdown in BUSY, and the DONE cycle sum to LAT.
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 2);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_o    = 1'b0;
    hilo_we_o = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = div_i ? DIV_RELOAD : MUL_RELOAD;
        end
      end
      MDU_BUSY: begin
        // A start here cannot arrive: decode is stalled while busy.
        busy_o = 1'b1;
        if (cnt_q == '0) state_d = MDU_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MDU_DONE: begin
        busy_o    = 1'b1;
        hilo_we_o = 1'b1;
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = div_i ? DIV_RELOAD : MUL_RELOAD;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use / branch / multicycle
// stalls, and decode/execute flush control.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       branch_d,
  input  logic       pcsrc_d,
  input  logic       hilo_rd_d,
  input  logic       mdu_op_d,
  input  logic       mdu_start_e,
  input  logic       mdu_div_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       forward_ad,
  output logic       forward_bd,
  output logic [1:0] forward_ae,
  output logic [1:0] forward_be,
  output logic       mdu_busy,
  output logic       hilo_we
);

  mdu_state_e mdu_state;
  logic       lwstall, brstall, mdustall, stall;
  logic       m_valid, w_valid;

  mdu_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu_seq (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mdu_start_e),
    .div_i     (mdu_div_e),
    .busy_o    (mdu_busy),
    .hilo_we_o (hilo_we),
    .state_o   (mdu_state)
  );

  // $0 is never a forwarding source.
  assign m_valid = regwrite_m && (writereg_m != 5'd0);
  assign w_valid = regwrite_w && (writereg_w != 5'd0);

  // Execute operand forwarding, memory stage wins over writeback.
  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    if      (m_valid && (writereg_m == rs_e)) forward_ae = FWD_MEM;
    else if (w_valid && (writereg_w == rs_e)) forward_ae = FWD_WB;
    if      (m_valid && (writereg_m == rt_e)) forward_be = FWD_MEM;
    else if (w_valid && (writereg_w == rt_e)) forward_be = FWD_WB;
  end

  // Decode-stage branch comparator forwards only from memory.
  assign forward_ad = m_valid && (writereg_m == rs_d);
  assign forward_bd = m_valid && (writereg_m == rt_d);

  // Stall sources; DONE releases the HI/LO consumer in the write cycle.
  always_comb begin
    lwstall  = memtoreg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    brstall  = branch_d &&
               ((regwrite_e && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                (memtoreg_m && ((writereg_m == rs_d) || (writereg_m == rt_d))));
    mdustall = (hilo_rd_d || mdu_op_d) &&
               (mdu_state != MDU_IDLE) && (mdu_state != MDU_DONE);
    stall    = lwstall || brstall || mdustall;
  end

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign flush_d = pcsrc_d && !stall;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a behavioural model that tracks the multicycle result by cycle.
module tb_hazard_controller;

  localparam int MUL = 4;
  localparam int DIV = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic       branch_d, pcsrc_d, hilo_rd_d, mdu_op_d, mdu_start_e, mdu_div_e;
  logic       stall_f, stall_d, flush_d, flush_e, forward_ad, forward_bd;
  logic [1:0] forward_ae, forward_be;
  logic       mdu_busy, hilo_we;

  int checks = 0;
  int errors = 0;
  // Model: cycle count, cycle a result was started and cycle it is written.
  int cyc = 0;
  int start_cyc = -1;
  int done_at = -1;
  int we_seen;

  hazard_controller #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .branch_d(branch_d), .pcsrc_d(pcsrc_d), .hilo_rd_d(hilo_rd_d),
    .mdu_op_d(mdu_op_d), .mdu_start_e(mdu_start_e), .mdu_div_e(mdu_div_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .mdu_busy(mdu_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_active();
    return (done_at >= 0) && (cyc > start_cyc) && (cyc <= done_at);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regwrite_m && writereg_m != 0 && writereg_m == src) return 2'd2;
    if (regwrite_w && writereg_w != 0 && writereg_w == src) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all();
    bit act, lw, br, ms, st;
    act = model_active();
    lw  = memtoreg_e && (rt_e == rs_d || rt_e == rt_d);
    br  = branch_d && ((regwrite_e && (writereg_e == rs_d || writereg_e == rt_d)) ||
                       (memtoreg_m && (writereg_m == rs_d || writereg_m == rt_d)));
    ms  = (hilo_rd_d || mdu_op_d) && act && (cyc < done_at);
    st  = lw || br || ms;
    chk("stall_f", stall_f, st);
    chk("stall_d", stall_d, st);
    chk("flush_e", flush_e, st);
    chk("flush_d", flush_d, pcsrc_d && !st);
    chk("forward_ae", forward_ae, fwd_sel(rs_e));
    chk("forward_be", forward_be, fwd_sel(rt_e));
    chk("forward_ad", forward_ad, regwrite_m && writereg_m != 0 && writereg_m == rs_d);
    chk("forward_bd", forward_bd, regwrite_m && writereg_m != 0 && writereg_m == rt_d);
    chk("mdu_busy", mdu_busy, act);
    chk("hilo_we", hilo_we, act && (cyc == done_at));
  endtask

  // Advance one clock and the model with it; returns at posedge+1.
  task automatic tick();
    bit act;
    act = model_active();
    @(posedge clk);
    if (reset) begin
      done_at = -1; start_cyc = -1;
    end else if (mdu_start_e && (!act || cyc == done_at)) begin
      start_cyc = cyc;
      done_at   = cyc + (mdu_div_e ? DIV : MUL);
    end
    cyc++;
    #1;
  endtask

  // Check mid-cycle, then clock.
  task automatic step();
    #3;
    check_all();
    tick();
  endtask

  task automatic zero_inputs();
    {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
    {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
    {branch_d, pcsrc_d, hilo_rd_d, mdu_op_d, mdu_start_e, mdu_div_e} = '0;
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    #2;
    // All outputs low during reset with idle inputs.
    chk("rst_outputs", {stall_f, stall_d, flush_d, flush_e, forward_ad, forward_bd, mdu_busy, hilo_we}, 8'h00);
    chk("rst_fwd", {forward_ae, forward_be}, 8'h00);
    @(posedge clk); #1;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_outputs", {stall_f, flush_d, forward_ae, forward_be, mdu_busy, hilo_we}, 8'h00);

    // Forward priority.
    regwrite_m = 1; regwrite_w = 1; writereg_m = 5; writereg_w = 5; rs_e = 5;
    #3; chk("fwd_mem", forward_ae, 2'b10); tick();
    writereg_m = 0;
    #3; chk("fwd_wb", forward_ae, 2'b01); tick();
    rs_e = 0;
    #3; chk("fwd_zero", forward_ae, 2'b00); tick();
    zero_inputs();

    // Load-use.
    memtoreg_e = 1; rt_e = 8; rs_d = 8;
    #3; chk("lw_stall", {stall_f, stall_d, flush_e}, 8'h07); check_all(); tick();
    rt_e = 9;
    #3; chk("lw_nostall", {stall_f, stall_d, flush_e}, 8'h00); check_all(); tick();
    zero_inputs();

    // Branch hazard with concurrent taken branch.
    branch_d = 1; regwrite_e = 1; writereg_e = 3; rt_d = 3; pcsrc_d = 1;
    #3; chk("br_stall", stall_d, 1'b1); chk("br_flush_held", flush_d, 1'b0); tick();
    regwrite_e = 0;
    #3; chk("br_flush", flush_d, 1'b1); chk("br_release", stall_d, 1'b0); tick();
    zero_inputs();

    // Multiply with HI/LO reader held in decode.
    mdu_start_e = 1; mdu_div_e = 0;
    step();
    mdu_start_e = 0; hilo_rd_d = 1;
    for (int i = 1; i <= 5; i++) begin
      #3;
      chk("mul_busy", mdu_busy, (i <= 4));
      chk("mul_we", hilo_we, (i == 4));
      chk("mul_stall", stall_d, (i <= 3));
      check_all();
      tick();
    end
    zero_inputs();

    // Divide, then back-to-back multiply started in the write cycle.
    mdu_start_e = 1; mdu_div_e = 1;
    step();
    mdu_start_e = 0;
    we_seen = 0;
    for (int i = 1; i <= 32 + MUL + 2; i++) begin
      if (i == 32) begin mdu_start_e = 1; mdu_div_e = 0; end
      else mdu_start_e = 0;
      #3;
      if (i == 32)       chk("div_we", hilo_we, 1'b1);
      if (i == 32 + MUL) chk("b2b_we", hilo_we, 1'b1);
      if (i == 33)       chk("b2b_busy", mdu_busy, 1'b1);
      if (hilo_we) we_seen++;
      check_all();
      tick();
    end
    chk("b2b_we_count", 8'(we_seen), 8'd2);
    zero_inputs();

    // Reset in the middle of a divide (counter at 10).
    mdu_start_e = 1; mdu_div_e = 1;
    step();
    mdu_start_e = 0;
    for (int i = 1; i <= 20; i++) step();
    #1; chk("mid_busy_before", mdu_busy, 1'b1);
    reset = 1'b1; done_at = -1; start_cyc = -1;
    #1; chk("mid_rst_busy", mdu_busy, 1'b0); chk("mid_rst_we", hilo_we, 1'b0);
    tick();
    step();
    reset = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      #3; if (hilo_we) we_seen++; check_all(); tick();
    end
    chk("mid_rst_no_we", 8'(we_seen), 8'd0);

    // Random traffic on a narrow register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      writereg_e = 5'($urandom_range(0, 3));
      writereg_m = 5'($urandom_range(0, 3));
      writereg_w = 5'($urandom_range(0, 3));
      {regwrite_e, regwrite_m, regwrite_w} = 3'($urandom);
      memtoreg_e = ($urandom_range(0, 3) == 0);
      memtoreg_m = ($urandom_range(0, 3) == 0);
      branch_d   = 1'($urandom);
      pcsrc_d    = 1'($urandom);
      hilo_rd_d  = 1'($urandom);
      mdu_op_d   = ($urandom_range(0, 3) == 0);
      mdu_start_e = ($urandom_range(0, 5) == 0);
      mdu_div_e   = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
